// File: rtl/count_down_tick.sv
// 4-bit synchronous down counter with parallel load, dual enables, borrow/ripple-borrow and a clk_50M prescaler.
// Optional build macro: DECADE_MODE_EN turns the counter into a BCD (0 -> 9 wrap) down counter.
module count_down_tick #(
    parameter logic [25:0] TIME = 26'd2
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       LD,
    input  logic       ct_t,
    input  logic       ct_p,
    input  logic [3:0] D,
    output logic       tick,
    output logic [3:0] Q,
    output logic       bo,
    output logic       rco
);

`ifdef DECADE_MODE_EN
    localparam logic [3:0] WRAP_VAL = 4'd9;
`else
    localparam logic [3:0] WRAP_VAL = 4'd15;
`endif

    logic [25:0] cnt;
    logic        cnt_last;
    logic        q_zero;
    logic        count_en;
    logic [3:0]  q_next;
    logic        rco_next;

    assign cnt_last = (cnt == (TIME - 26'd1));
    assign q_zero   = (Q == 4'd0);
    assign count_en = ct_t & ct_p;

    // Prescaler: tick is registered, so it is high in the cycle after cnt reaches TIME-1.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 26'd0;
            tick <= 1'b0;
        end else begin
            tick <= cnt_last;
            cnt  <= cnt_last ? 26'd0 : (cnt + 26'd1);
        end
    end

    // Load beats count; a wrap only raises rco when it is not overridden by a load.
    always_comb begin
        q_next   = Q;
        rco_next = 1'b0;
        if (tick) begin
            if (!LD) begin
                q_next = D;
            end else if (count_en) begin
                if (q_zero) begin
                    q_next   = WRAP_VAL;
                    rco_next = 1'b1;
                end else begin
                    q_next = Q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            Q   <= 4'd0;
            rco <= 1'b0;
        end else begin
            Q   <= q_next;
            rco <= rco_next;
        end
    end

    assign bo = ct_t & q_zero;

endmodule
